// File: rtl/spi_syn_slave_param.sv
// spi_syn_slave_param
//   SPI slave with configurable word width, SPI mode (CPOL/CPHA) and bit
//   order. The SPI pins are oversampled in the clk domain. A single-word
//   holding register with a valid/ready handshake feeds the transmit path.
//
// Ports
//   clk, rst_n          fabric clock, asynchronous active-low reset
//   tx_data/tx_valid    word offered for the next transmission
//   tx_ready            holding register empty (write when valid && ready)
//   rx_data             last complete received word
//   rx_valid            one-cycle pulse when rx_data updates
//   tx_underrun         one-cycle pulse when a word starts with no tx data
//   busy                slave is selected (synchronised cs low)
//   sclk, cs, mosi      SPI pins from the master (asynchronous to clk)
//   miso                slave-out data, 0 while not selected
module spi_syn_slave_param #(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              busy,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso
);

  localparam logic SCLK_IDLE   = (CPOL != 0);
  localparam bit   SAMPLE_RISE = (CPOL == CPHA);
  localparam int   CNT_W       = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sample_edge, shift_edge, cs_fall, cs_rise;

  state_t                 state;
  logic [DATA_W-1:0]      hold_reg, tx_sr, rx_sr;
  logic                   hold_full;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   reload_pend, skip_shift;

  logic                   wr_en, load_now, tx_out_bit;
  logic [DATA_W-1:0]      load_word, rx_next, tx_shifted;

  // Pin synchronisers; the extra sclk/cs registers give edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= {SYNC_STAGES{SCLK_IDLE}};
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= SCLK_IDLE;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sample_edge = SAMPLE_RISE ? (sclk_s & ~sclk_d) : (~sclk_s & sclk_d);
  assign shift_edge  = SAMPLE_RISE ? (~sclk_s & sclk_d) : (sclk_s & ~sclk_d);
  assign cs_fall     = cs_d & ~cs_s;
  assign cs_rise     = ~cs_d & cs_s;

  assign tx_ready   = ~hold_full;
  assign busy       = (state == ACTIVE);
  assign tx_out_bit = (MSB_FIRST != 0) ? tx_sr[DATA_W-1] : tx_sr[0];
  assign miso       = busy & tx_out_bit;

  assign wr_en     = tx_valid & tx_ready;
  // An empty holding register transmits zeros.
  assign load_word = hold_full ? hold_reg : '0;
  assign load_now  = ((state == IDLE) && cs_fall) ||
                     ((state == ACTIVE) && !cs_rise && shift_edge && reload_pend);

  assign rx_next    = (MSB_FIRST != 0) ? {rx_sr[DATA_W-2:0], mosi_s}
                                       : {mosi_s, rx_sr[DATA_W-1:1]};
  assign tx_shifted = (MSB_FIRST != 0) ? {tx_sr[DATA_W-2:0], 1'b0}
                                       : {1'b0, tx_sr[DATA_W-1:1]};

  // Holding register. A write is only accepted when empty, so a write that
  // coincides with a load leaves the new word stored and tx_ready low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg  <= '0;
      hold_full <= 1'b0;
    end else if (wr_en) begin
      hold_reg  <= tx_data;
      hold_full <= 1'b1;
    end else if (load_now) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tx_sr       <= '0;
      rx_sr       <= '0;
      bit_cnt     <= '0;
      reload_pend <= 1'b0;
      skip_shift  <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state       <= ACTIVE;
            tx_sr       <= load_word;
            tx_underrun <= ~hold_full;
            // With CPHA=1 the first bit is already on miso, so the first
            // shift edge must not advance the register.
            skip_shift  <= (CPHA != 0);
            bit_cnt     <= '0;
            rx_sr       <= '0;
            reload_pend <= 1'b0;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            // Abort: any partial word is dropped silently.
            state       <= IDLE;
            tx_sr       <= '0;
            rx_sr       <= '0;
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
            skip_shift  <= 1'b0;
          end else begin
            if (sample_edge) begin
              rx_sr <= rx_next;
              if (bit_cnt == LAST_BIT) begin
                rx_data     <= rx_next;
                rx_valid    <= 1'b1;
                bit_cnt     <= '0;
                reload_pend <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
            if (shift_edge) begin
              // After a completed word the next shift edge presents the
              // first bit of the following word instead of shifting.
              if (reload_pend) begin
                tx_sr       <= load_word;
                tx_underrun <= ~hold_full;
                reload_pend <= 1'b0;
              end else if (skip_shift) begin
                skip_shift <= 1'b0;
              end else begin
                tx_sr <= tx_shifted;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
